// File: rtl/spi_cntrl.sv
// spi_cntrl: APB-style register file feeding an SPI master that runs
// up to 8 queued address/data transactions (mode 0, MSB first).
// Ports: pclk_i/prst_i clock and sync reset; paddr_i/penable_i/pwrite_i/
// pwdata_i -> pready_o/prdata_o/perror_o register access; psel_i slave
// index; sclk_o/mosi/miso/cs SPI pins; sclk_ref_i reserved, unused.
module spi_cntrl #(
  parameter int NUM_BITS = 8
) (
  input  logic                pclk_i,
  input  logic                prst_i,
  input  logic [NUM_BITS-1:0] paddr_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [NUM_BITS-1:0] pwdata_i,
  output logic                pready_o,
  output logic [NUM_BITS-1:0] prdata_o,
  output logic                perror_o,
  input  logic [2:0]          psel_i,
  output logic                sclk_o,
  output logic                mosi,
  input  logic                miso,
  output logic [2:0]          cs,
  input  logic                sclk_ref_i
);

  localparam int CW = $clog2(4 * NUM_BITS);
  localparam logic [CW-1:0] LAST = CW'(4 * NUM_BITS - 1);
  localparam logic [CW-1:0] HALF = CW'(2 * NUM_BITS);

  typedef enum logic [1:0] {
    IDLE, CS_SETUP, SHIFT, GAP
  } state_t;

  state_t state_q, state_d;

  logic [NUM_BITS-1:0]   addr_reg [8];
  logic [NUM_BITS-1:0]   data_reg [8];
  logic [2:0]            num_m1_q;
  logic [2:0]            k_q;
  logic [1:0]            sel_q;
  logic [CW-1:0]         cnt_q;
  logic [2*NUM_BITS-1:0] tx_q;
  logic [NUM_BITS-2:0]   rx_q;

  logic                busy, acc, wr;
  logic                in_addr, in_data, in_ctrl;
  logic                valid, bad_sel, err;
  logic                start_ok, last_tx, is_wr_tx;
  logic [2:0]          idx;
  logic [2:0]          cs_on;
  logic [NUM_BITS-1:0] rdata;
  logic                unused_ref;

  assign unused_ref = sclk_ref_i;

  assign busy    = state_q != IDLE;
  assign acc     = penable_i & ~pready_o;
  assign wr      = acc & pwrite_i;
  assign idx     = paddr_i[2:0];
  assign in_addr = (paddr_i >> 3) == NUM_BITS'(0);
  assign in_data = (paddr_i >> 3) == NUM_BITS'(2);
  assign in_ctrl = paddr_i == NUM_BITS'('h20);
  assign valid   = in_addr | in_data | in_ctrl;
  assign bad_sel = pwdata_i[0] & (psel_i > 3'd2);

  // Writes while a queue is running are rejected outright.
  assign err = ~valid
             | (pwrite_i & busy)
             | (pwrite_i & in_ctrl & bad_sel);

  assign start_ok = wr & in_ctrl & ~busy
                  & pwdata_i[0] & ~bad_sel;

  assign last_tx  = k_q == num_m1_q;
  assign is_wr_tx = addr_reg[k_q][NUM_BITS-1];
  assign cs_on    = ~(3'b001 << sel_q);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      in_addr: rdata = addr_reg[idx];
      in_data: rdata = data_reg[idx];
      in_ctrl: rdata = NUM_BITS'({num_m1_q, busy});
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cs      = 3'b111;
    sclk_o  = 1'b0;
    mosi    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = CS_SETUP;
      end
      CS_SETUP: begin
        cs      = cs_on;
        state_d = SHIFT;
      end
      SHIFT: begin
        cs     = cs_on;
        sclk_o = cnt_q[0];
        mosi   = tx_q[2*NUM_BITS-1];
        if (cnt_q == LAST) state_d = GAP;
      end
      GAP: begin
        if (cnt_q[0])
          state_d = last_tx ? IDLE : CS_SETUP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      for (int i = 0; i < 8; i++) begin
        addr_reg[i] <= '0;
        data_reg[i] <= '0;
      end
      num_m1_q <= '0;
      k_q      <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      pready_o <= 1'b0;
      prdata_o <= '0;
      perror_o <= 1'b0;
    end else begin
      pready_o <= acc;
      prdata_o <= (acc & ~pwrite_i) ? rdata : '0;
      perror_o <= acc & err;

      if (wr & ~err) begin
        if (in_addr) addr_reg[idx] <= pwdata_i;
        if (in_data) data_reg[idx] <= pwdata_i;
        if (in_ctrl) num_m1_q <= pwdata_i[3:1];
      end

      if (start_ok) begin
        sel_q <= psel_i[1:0];
        k_q   <= '0;
      end

      case (state_q)
        CS_SETUP: begin
          cnt_q <= '0;
          // Read transactions shift zeros in the data phase.
          tx_q  <= {addr_reg[k_q],
                    {NUM_BITS{is_wr_tx}} & data_reg[k_q]};
        end
        SHIFT: begin
          cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
          // Odd count = sclk high; advance at its end.
          if (cnt_q[0]) begin
            tx_q <= tx_q << 1;
            if (cnt_q >= HALF)
              rx_q <= {rx_q[NUM_BITS-3:0], miso};
          end
          if (cnt_q == LAST && !is_wr_tx)
            data_reg[k_q] <= {rx_q, miso};
        end
        GAP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q[0] && !last_tx) k_q <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cntrl.sv
// tb_spi_cntrl: directed bench for spi_cntrl with a timeline model
// checked every cycle plus literal expectations.
module tb_spi_cntrl;

  logic       pclk_i = 1'b0;
  logic       prst_i = 1'b1;
  logic [7:0] paddr_i = '0;
  logic       penable_i = 1'b0;
  logic       pwrite_i = 1'b0;
  logic [7:0] pwdata_i = '0;
  logic       pready_o;
  logic [7:0] prdata_o;
  logic       perror_o;
  logic [2:0] psel_i = '0;
  logic       sclk_o;
  logic       mosi;
  logic       miso = 1'b0;
  logic [2:0] cs;
  logic       sclk_ref_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int fail_prints = 0;

  spi_cntrl #(.NUM_BITS(8)) dut (
    .pclk_i    (pclk_i),
    .prst_i    (prst_i),
    .paddr_i   (paddr_i),
    .penable_i (penable_i),
    .pwrite_i  (pwrite_i),
    .pwdata_i  (pwdata_i),
    .pready_o  (pready_o),
    .prdata_o  (prdata_o),
    .perror_o  (perror_o),
    .psel_i    (psel_i),
    .sclk_o    (sclk_o),
    .mosi      (mosi),
    .miso      (miso),
    .cs        (cs),
    .sclk_ref_i(sclk_ref_i)
  );

  always #5 pclk_i = ~pclk_i;
  always #7 sclk_ref_i = ~sclk_ref_i;

  // Model state: register image plus the start time of the
  // current queue; a transaction occupies 35 cycles.
  int         cyc = 0;
  logic [7:0] m_addr [8];
  logic [7:0] m_data [8];
  logic [2:0] m_nm1;
  int         m_sel, m_start, m_n;
  bit         m_active = 1'b0;
  bit         m_pready = 1'b0;
  bit         m_perror = 1'b0;
  logic [7:0] m_prdata = '0;

  function automatic bit m_busy(int c);
    return m_active && c > m_start &&
           (c - 1 - m_start) < 35 * m_n;
  endfunction

  always @(posedge pclk_i) begin
    int a, rel;
    bit bz, er;
    logic [7:0] rd;
    cyc = cyc + 1;
    if (prst_i) begin
      for (int i = 0; i < 8; i++) begin
        m_addr[i] = 8'h00;
        m_data[i] = 8'h00;
      end
      m_nm1 = 3'd0;
      m_active = 1'b0;
      m_pready = 1'b0;
      m_perror = 1'b0;
      m_prdata = 8'h00;
    end else begin
      if (m_active) begin
        rel = cyc - m_start;
        if (rel < 35 * m_n && rel % 35 == 33 &&
            !m_addr[rel / 35][7])
          m_data[rel / 35] = {8{miso}};
      end
      if (penable_i && !m_pready) begin
        a  = int'(paddr_i);
        bz = m_busy(cyc);
        rd = 8'h00;
        er = 1'b0;
        if (!(a < 8 || (a >= 16 && a < 24) || a == 32)) begin
          er = 1'b1;
        end else if (pwrite_i) begin
          if (bz) begin
            er = 1'b1;
          end else if (a == 32) begin
            if (pwdata_i[0] && psel_i > 3'd2) begin
              er = 1'b1;
            end else begin
              m_nm1 = pwdata_i[3:1];
              if (pwdata_i[0]) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_n      = int'(m_nm1) + 1;
                m_sel    = int'(psel_i);
              end
            end
          end else if (a < 8) begin
            m_addr[a] = pwdata_i;
          end else begin
            m_data[a - 16] = pwdata_i;
          end
        end else begin
          if (a < 8)       rd = m_addr[a];
          else if (a < 24) rd = m_data[a - 16];
          else             rd = {4'b0, m_nm1, bz};
        end
        m_pready = 1'b1;
        m_prdata = rd;
        m_perror = er;
      end else begin
        m_pready = 1'b0;
      end
    end
  end

  bit sclk_prev = 1'b0;
  int rise_cnt = 0;
  int cs_low_cnt = 0;
  bit bits[$];

  always @(negedge pclk_i) begin
    int rel, t, p, j;
    logic [2:0] e_cs;
    logic e_sclk, e_mosi;
    logic [15:0] w;
    bit bad;
    if (cyc >= 1) begin
      e_cs = 3'b111;
      e_sclk = 1'b0;
      e_mosi = 1'b0;
      if (m_active) begin
        rel = cyc - m_start;
        if (rel < 35 * m_n) begin
          t = rel / 35;
          p = rel % 35;
          if (p <= 32) e_cs = ~(3'b001 << m_sel);
          if (p >= 1 && p <= 32) begin
            j = (p - 1) / 2;
            e_sclk = ((p - 1) % 2) == 1;
            w = {m_addr[t],
                 m_addr[t][7] ? m_data[t] : 8'h00};
            e_mosi = w[15 - j];
          end
        end
      end
      bad = cs !== e_cs || sclk_o !== e_sclk ||
            mosi !== e_mosi || pready_o !== m_pready ||
            (m_pready && (prdata_o !== m_prdata ||
                          perror_o !== m_perror));
      checks++;
      if (bad) begin
        errors++;
        if (fail_prints < 30) begin
          fail_prints++;
          $display("FAIL cycle %0d got/exp: cs=%b/%b sclk=%b/%b mosi=%b/%b pready=%b/%b prdata=%h/%h perror=%b/%b",
                   cyc, cs, e_cs, sclk_o, e_sclk, mosi, e_mosi,
                   pready_o, m_pready, prdata_o, m_prdata,
                   perror_o, m_perror);
        end
      end
      if (sclk_o && !sclk_prev) begin
        rise_cnt++;
        bits.push_back(mosi);
      end
      sclk_prev = sclk_o;
      if (cs != 3'b111) cs_low_cnt++;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apb(input logic [7:0] a, input bit w,
                     input logic [7:0] d,
                     output logic [7:0] rd, output bit er);
    @(negedge pclk_i);
    paddr_i = a;
    pwrite_i = w;
    pwdata_i = d;
    penable_i = 1'b1;
    @(negedge pclk_i);
    rd = prdata_o;
    er = perror_o;
    penable_i = 1'b0;
    @(negedge pclk_i);
  endtask

  function automatic logic [15:0] word_at(int k);
    logic [15:0] w;
    w = 'x;
    if (bits.size() >= 16 * (k + 1)) begin
      for (int j = 0; j < 16; j++)
        w[15 - j] = bits[16 * k + j];
    end
    return w;
  endfunction

  task automatic clear_obs();
    rise_cnt = 0;
    cs_low_cnt = 0;
    bits.delete();
  endtask

  logic [15:0] exp_words [8] = '{
    16'hD353, 16'hD454, 16'hD555, 16'hD656,
    16'hD757, 16'hD858, 16'hD959, 16'hDA5A
  };

  initial begin
    logic [7:0] rd;
    bit er;

    prst_i = 1'b1;
    @(negedge pclk_i);
    prst_i = 1'b0;
    chk("rst_cs", 32'(cs), 32'h7);
    chk("rst_sclk", 32'(sclk_o), 32'h0);
    chk("rst_pready", 32'(pready_o), 32'h0);
    apb(8'h20, 1'b0, 8'h00, rd, er);
    chk("ctrl_rst", 32'(rd), 32'h00);
    chk("ctrl_rst_err", 32'(er), 32'h0);

    for (int i = 0; i < 8; i++) begin
      apb(8'(i), 1'b1, 8'(8'hD3 + i), rd, er);
      chk("wr_addr_err", 32'(er), 32'h0);
      apb(8'(16 + i), 1'b1, 8'(8'h53 + i), rd, er);
      chk("wr_data_err", 32'(er), 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      apb(8'(i), 1'b0, 8'h00, rd, er);
      chk("rb_addr", 32'(rd), 32'(8'hD3 + i));
      apb(8'(16 + i), 1'b0, 8'h00, rd, er);
      chk("rb_data", 32'(rd), 32'(8'h53 + i));
    end

    miso = 1'b1;
    psel_i = 3'd0;
    clear_obs();
    apb(8'h20, 1'b1, 8'h0F, rd, er);
    chk("start8_err", 32'(er), 32'h0);
    repeat (40) @(negedge pclk_i);
    apb(8'h20, 1'b0, 8'h00, rd, er);
    chk("ctrl_busy", 32'(rd), 32'h0F);
    apb(8'h20, 1'b1, 8'h0B, rd, er);
    chk("wr_busy_err", 32'(er), 32'h1);
    repeat (260) @(negedge pclk_i);
    chk("rise8", 32'(rise_cnt), 32'd128);
    chk("cslow8", 32'(cs_low_cnt), 32'd264);
    for (int k = 0; k < 8; k++)
      chk("word8", 32'(word_at(k)), 32'(exp_words[k]));
    apb(8'h20, 1'b0, 8'h00, rd, er);
    chk("ctrl_idle8", 32'(rd), 32'h0E);

    clear_obs();
    apb(8'h20, 1'b1, 8'h0B, rd, er);
    chk("start6_err", 32'(er), 32'h0);
    repeat (215) @(negedge pclk_i);
    chk("rise6", 32'(rise_cnt), 32'd96);
    chk("cslow6", 32'(cs_low_cnt), 32'd198);
    chk("word6_last", 32'(word_at(5)), 32'h0000D858);
    apb(8'h20, 1'b0, 8'h00, rd, er);
    chk("ctrl_idle6", 32'(rd), 32'h0A);

    apb(8'h00, 1'b1, 8'h12, rd, er);
    clear_obs();
    apb(8'h20, 1'b1, 8'h01, rd, er);
    chk("start_rd_err", 32'(er), 32'h0);
    repeat (40) @(negedge pclk_i);
    chk("word_rd", 32'(word_at(0)), 32'h00001200);
    chk("rise_rd", 32'(rise_cnt), 32'd16);
    apb(8'h10, 1'b0, 8'h00, rd, er);
    chk("rd_ff", 32'(rd), 32'hFF);
    miso = 1'b0;
    apb(8'h20, 1'b1, 8'h01, rd, er);
    repeat (40) @(negedge pclk_i);
    apb(8'h10, 1'b0, 8'h00, rd, er);
    chk("rd_00", 32'(rd), 32'h00);
    apb(8'h20, 1'b0, 8'h00, rd, er);
    chk("ctrl_n1", 32'(rd), 32'h00);

    apb(8'h30, 1'b0, 8'h00, rd, er);
    chk("inv_rd_err", 32'(er), 32'h1);
    chk("inv_rd_data", 32'(rd), 32'h00);
    apb(8'h30, 1'b1, 8'h55, rd, er);
    chk("inv_wr_err", 32'(er), 32'h1);
    apb(8'h08, 1'b0, 8'h00, rd, er);
    chk("inv_08_err", 32'(er), 32'h1);
    apb(8'h17, 1'b0, 8'h00, rd, er);
    chk("data7_err", 32'(er), 32'h0);
    chk("data7", 32'(rd), 32'h5A);

    psel_i = 3'd5;
    apb(8'h20, 1'b1, 8'h01, rd, er);
    chk("sel5_err", 32'(er), 32'h1);
    psel_i = 3'd3;
    apb(8'h20, 1'b1, 8'h01, rd, er);
    chk("sel3_err", 32'(er), 32'h1);
    repeat (5) @(negedge pclk_i);
    chk("sel_bad_cs", 32'(cs), 32'h7);

    psel_i = 3'd2;
    apb(8'h20, 1'b1, 8'h01, rd, er);
    chk("sel2_err", 32'(er), 32'h0);
    repeat (10) @(negedge pclk_i);
    chk("sel2_cs", 32'(cs), 32'h3);
    prst_i = 1'b1;
    @(negedge pclk_i);
    prst_i = 1'b0;
    chk("midrst_cs", 32'(cs), 32'h7);
    chk("midrst_sclk", 32'(sclk_o), 32'h0);
    apb(8'h17, 1'b0, 8'h00, rd, er);
    chk("midrst_data", 32'(rd), 32'h00);
    apb(8'h20, 1'b0, 8'h00, rd, er);
    chk("midrst_ctrl", 32'(rd), 32'h00);
    repeat (40) @(negedge pclk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
